// File: rtl/cpu_cycle_controller_if.sv
// Memory bus handshake between the cycle controller and the bus interface.
//   waitrequest  : bus stall; a transfer completes in the cycle it is low
//   mem_read     : read request
//   mem_write    : write request
//   mem_addr_sel : 0 = PC drives the bus address, 1 = ALU result drives it
// master = cycle controller (issues requests), slave = bus interface.
interface cpu_cycle_controller_if;
    logic waitrequest;
    logic mem_read;
    logic mem_write;
    logic mem_addr_sel;

    modport master (input waitrequest, output mem_read, output mem_write, output mem_addr_sel);
    modport slave  (output waitrequest, input mem_read, input mem_write, input mem_addr_sel);
endinterface

// File: rtl/cpu_cycle_controller.sv
// Multi-cycle sequencer for the MIPS core: FETCH -> EXEC [-> MEM] -> FETCH,
// stalling on waitrequest and stopping for good when the PC hits HALT_ADDRESS.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   pc_address          : current PC
//   is_load, is_store   : decoded instruction class (valid from EXEC on)
//   bus                 : memory bus handshake (master side)
//   cycle_1/2/3         : fetch / execute / data-memory phase strobes
//   instr_latch_en      : instruction register load enable
//   load_data_en        : load-data register capture enable
//   active              : low only once halted
//   retired_count       : instructions completed since reset (wraps)
//   bus_error           : sticky wait-timeout flag
// Optional feature: define CPU_CYCLE_CONTROLLER_WAIT_TIMEOUT_EN to halt with
// bus_error after MAX_WAIT consecutive stalled cycles; otherwise stalls are
// unbounded and bus_error is 0.
module cpu_cycle_controller #(
    parameter logic [31:0] HALT_ADDRESS = 32'h0000_0000,
    parameter int          MAX_WAIT     = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [31:0]                   pc_address,
    input  logic                          is_load,
    input  logic                          is_store,
    cpu_cycle_controller_if.master        bus,
    output logic                          cycle_1,
    output logic                          cycle_2,
    output logic                          cycle_3,
    output logic                          instr_latch_en,
    output logic                          load_data_en,
    output logic                          active,
    output logic [31:0]                   retired_count,
    output logic                          bus_error
);

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALTED} state_t;

    state_t      state_q, state_d;
    logic [31:0] retired_count_q, retired_count_d;
    logic        stall;

`ifdef CPU_CYCLE_CONTROLLER_WAIT_TIMEOUT_EN
    localparam int WAIT_W = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              bus_error_q, bus_error_d;
`endif

    // Outputs decode from state and live inputs so requests fall the moment
    // reset rises, without waiting for an edge.
    always_comb begin
        state_d          = state_q;
        retired_count_d  = retired_count_q;
        stall            = 1'b0;
        cycle_1          = 1'b0;
        cycle_2          = 1'b0;
        cycle_3          = 1'b0;
        bus.mem_read     = 1'b0;
        bus.mem_write    = 1'b0;
        bus.mem_addr_sel = 1'b0;
        instr_latch_en   = 1'b0;
        load_data_en     = 1'b0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    cycle_1 = 1'b1;
                    if (pc_address == HALT_ADDRESS) begin
                        state_d = S_HALTED;
                    end else begin
                        bus.mem_read = 1'b1;
                        stall        = bus.waitrequest;
                        if (!bus.waitrequest) begin
                            instr_latch_en = 1'b1;
                            state_d        = S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    cycle_2 = 1'b1;
                    if (is_load || is_store) begin
                        state_d = S_MEM;
                    end else begin
                        retired_count_d = retired_count_q + 32'd1;
                        state_d         = S_FETCH;
                    end
                end
                S_MEM: begin
                    // Load wins if both decode bits are set (illegal encoding).
                    cycle_3          = 1'b1;
                    bus.mem_addr_sel = 1'b1;
                    bus.mem_read     = is_load;
                    bus.mem_write    = is_store && !is_load;
                    stall            = bus.waitrequest;
                    if (!bus.waitrequest) begin
                        load_data_en    = is_load;
                        retired_count_d = retired_count_q + 32'd1;
                        state_d         = S_FETCH;
                    end
                end
                default: ;  // S_HALTED: terminal until reset
            endcase
        end

`ifdef CPU_CYCLE_CONTROLLER_WAIT_TIMEOUT_EN
        // Counts only consecutive stalled cycles; any completion or state
        // change clears it.
        wait_cnt_d  = '0;
        bus_error_d = bus_error_q;
        if (stall) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
            if (wait_cnt_d == WAIT_W'(MAX_WAIT)) begin
                state_d     = S_HALTED;
                bus_error_d = 1'b1;
                wait_cnt_d  = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= S_FETCH;
            retired_count_q <= 32'd0;
`ifdef CPU_CYCLE_CONTROLLER_WAIT_TIMEOUT_EN
            wait_cnt_q      <= '0;
            bus_error_q     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            retired_count_q <= retired_count_d;
`ifdef CPU_CYCLE_CONTROLLER_WAIT_TIMEOUT_EN
            wait_cnt_q      <= wait_cnt_d;
            bus_error_q     <= bus_error_d;
`endif
        end
    end

    assign active        = (state_q != S_HALTED);
    assign retired_count = retired_count_q;

`ifdef CPU_CYCLE_CONTROLLER_WAIT_TIMEOUT_EN
    assign bus_error = bus_error_q;
`else
    // Always 0; MAX_WAIT is referenced so the default build still elaborates it.
    assign bus_error = (MAX_WAIT < 0);
`endif

endmodule

// File: tb/tb_cpu_cycle_controller.sv
module tb_cpu_cycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_address;
    logic        is_load, is_store;
    logic        cycle_1, cycle_2, cycle_3;
    logic        instr_latch_en, load_data_en, active, bus_error;
    logic [31:0] retired_count;

    cpu_cycle_controller_if bus_if();

    cpu_cycle_controller #(.HALT_ADDRESS(32'h0000_0000), .MAX_WAIT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_address     (pc_address),
        .is_load        (is_load),
        .is_store       (is_store),
        .bus            (bus_if.master),
        .cycle_1        (cycle_1),
        .cycle_2        (cycle_2),
        .cycle_3        (cycle_3),
        .instr_latch_en (instr_latch_en),
        .load_data_en   (load_data_en),
        .active         (active),
        .retired_count  (retired_count),
        .bus_error      (bus_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // One planned cycle: inputs to drive and the outputs expected that cycle.
    typedef struct {
        logic        wr;
        logic        ld;
        logic        st;
        logic [9:0]  ev;
        logic [31:0] er;
    } step_t;

    step_t       plan[$];
    logic [31:0] model_ret;

    // Observed vector: {c1,c2,c3,rd,wr,sel,latch,lde,active,bus_error}
    function automatic logic [9:0] obs();
        return {cycle_1, cycle_2, cycle_3, bus_if.mem_read, bus_if.mem_write,
                bus_if.mem_addr_sel, instr_latch_en, load_data_en, active, bus_error};
    endfunction

    // Expected vector for a running (active, no bus error) cycle.
    function automatic logic [9:0] mk(logic c1, logic c2, logic c3, logic rd,
                                      logic wr, logic sel, logic lat, logic lde);
        return {c1, c2, c3, rd, wr, sel, lat, lde, 1'b1, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, o, e);
        end
    endtask

    task automatic add(input logic wr, input logic ld, input logic st, input logic [9:0] ev);
        step_t s;
        s.wr = wr; s.ld = ld; s.st = st; s.ev = ev; s.er = model_ret;
        plan.push_back(s);
    endtask

    // Instruction-level model: kind 0=ALU 1=load 2=store 3=load+store (acts as load).
    // wf/wm = stalled cycles before the fetch / memory transfer completes.
    task automatic push_instr(input int kind, input int wf, input int wm);
        logic ld, st, eld, est;
        ld  = (kind == 1 || kind == 3);
        st  = (kind == 2 || kind == 3);
        eld = ld;
        est = st && !ld;
        for (int i = 0; i < wf; i++) add(1'b1, ld, st, mk(1,0,0,1,0,0,0,0));
        add(1'b0, ld, st, mk(1,0,0,1,0,0,1,0));
        add(1'($urandom_range(0, 1)), ld, st, mk(0,1,0,0,0,0,0,0));
        if (kind == 0) begin
            model_ret = model_ret + 32'd1;
        end else begin
            for (int i = 0; i < wm; i++) add(1'b1, ld, st, mk(0,0,1,eld,est,1,0,0));
            add(1'b0, ld, st, mk(0,0,1,eld,est,1,0,eld));
            model_ret = model_ret + 32'd1;
        end
    endtask

    task automatic run_plan(input string tag);
        step_t s;
        while (plan.size() != 0) begin
            s = plan.pop_front();
            bus_if.waitrequest = s.wr;
            is_load            = s.ld;
            is_store           = s.st;
            @(negedge clk);
            chk({tag, "_out"}, 32'(obs()), 32'(s.ev));
            chk({tag, "_ret"}, retired_count, s.er);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset              = 1'b1;
        pc_address         = 32'hBFC0_0000;
        bus_if.waitrequest = 1'b1;
        is_load            = 1'b1;
        is_store           = 1'b0;
        model_ret          = 32'd0;

        // Reset: strobes/requests low, active high, counters clear.
        @(posedge clk); #1;
        chk("reset_out", 32'(obs()), 32'(10'b0000000010));
        chk("reset_ret", retired_count, 32'd0);
        reset = 1'b0;

        // Two ALU instructions back to back, no stalls.
        push_instr(0, 0, 0);
        push_instr(0, 0, 0);
        run_plan("alu2");
        chk("alu2_retired", retired_count, 32'd2);

        // Load with 3 stalled MEM cycles, then a clean store.
        push_instr(1, 0, 3);
        run_plan("load_w3");
        push_instr(2, 0, 0);
        run_plan("store");

        // Random mix of instruction kinds and stall lengths.
        pc_address = $urandom | 32'h0000_0004;
        for (int n = 0; n < 40; n++) begin
            push_instr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_plan("rand");
        chk("rand_retired", retired_count, model_ret);

        // PC reaches the halt address: no read, then permanently inactive.
        pc_address         = 32'h0;
        bus_if.waitrequest = 1'b0;
        @(negedge clk);
        chk("halt_fetch", 32'(obs()), 32'(10'b1000000010));
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("halted", 32'(obs()), 32'(10'b0));
            @(posedge clk); #1;
        end
        chk("halted_ret", retired_count, model_ret);

        // Reset during a FETCH stall drops the request immediately.
        reset = 1'b1;
        @(posedge clk); #1;
        reset              = 1'b0;
        pc_address         = 32'hBFC0_0000;
        bus_if.waitrequest = 1'b1;
        @(negedge clk);
        chk("stall_fetch", 32'(obs()), 32'(mk(1,0,0,1,0,0,0,0)));
        #2 reset = 1'b1;
        #1;
        chk("async_reset_out", 32'(obs()), 32'(10'b0000000010));
        chk("async_reset_ret", retired_count, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("restart_fetch", 32'(obs()), 32'(mk(1,0,0,1,0,0,0,0)));
        chk("restart_ret", retired_count, 32'd0);

`ifdef CPU_CYCLE_CONTROLLER_WAIT_TIMEOUT_EN
        // Stuck waitrequest: the 4th stalled cycle trips the timeout.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("timeout_stall", 32'(obs()), 32'(mk(1,0,0,1,0,0,0,0)));
        end
        @(posedge clk); #1;
        @(negedge clk);
        chk("timeout_halt", 32'(obs()), 32'(10'b0000000001));
`else
        // Stuck waitrequest: stall indefinitely, never flag an error.
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("long_stall", 32'(obs()), 32'(mk(1,0,0,1,0,0,0,0)));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_cycle_controller.md
Name: cpu_cycle_controller

Overview:
- Multi-cycle sequencer for the MIPS core.
- Generates the per-instruction phase strobes that step the program counter: cycle_1 (fetch, PC holds) and cycle_2 (execute, PC loads next address).
- Adds a data-memory phase for loads/stores, stalls on bus waitrequest, and halts the core when the PC reaches the halt address.
- Sits between the memory bus interface and the PC, instruction register, register file and load-data register.

Parameters:
- HALT_ADDRESS, 32'h00000000, PC value at which execution stops.
- MAX_WAIT, 255, maximum consecutive waitrequest cycles before bus error (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- pc_address  input  32  current PC output.
- waitrequest  input  1  memory bus stall; transfer completes in the cycle it is low.
- is_load  input  1  decoded instruction is a load; valid in EXEC.
- is_store  input  1  decoded instruction is a store; valid in EXEC.
- cycle_1  output  1  fetch phase strobe to PC.
- cycle_2  output  1  execute phase strobe to PC; PC updates at the end of this cycle.
- cycle_3  output  1  data-memory phase strobe.
- mem_read  output  1  bus read request.
- mem_write  output  1  bus write request.
- mem_addr_sel  output  1  0 = PC drives the bus address, 1 = ALU result drives it.
- instr_latch_en  output  1  instruction register load enable.
- load_data_en  output  1  load-data register capture enable.
- active  output  1  high while the core runs.
- retired_count  output  32  number of instructions completed since reset.
- bus_error  output  1  wait timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- States: FETCH, EXEC, MEM, HALTED.
- Outputs are decoded from the state plus inputs; the state and counters are registered.
- Reset (asynchronous):
  - state = FETCH, retired_count = 0, bus_error = 0.
  - During reset all strobes and requests are forced to 0; active = 1.
  - Leaving reset, the first cycle is FETCH.
- FETCH:
  - cycle_1 = 1, mem_addr_sel = 0.
  - If pc_address == HALT_ADDRESS: mem_read = 0, next state HALTED. No bus request is issued.
  - Otherwise: mem_read = 1.
    - waitrequest = 1: stay in FETCH.
    - waitrequest = 0: instr_latch_en = 1, next state EXEC.
- EXEC:
  - Lasts exactly 1 cycle; cycle_2 = 1; no bus request.
  - is_load or is_store: next state MEM.
  - Otherwise: retired_count += 1, next state FETCH.
  - is_load and is_store both high is illegal; treat it as a load.
- MEM:
  - cycle_3 = 1, mem_addr_sel = 1, mem_read = is_load, mem_write = is_store.
  - The decode inputs stay stable because the instruction register is not reloaded.
  - waitrequest = 1: stay in MEM.
  - waitrequest = 0: load_data_en = is_load, retired_count += 1, next state FETCH.
  - The PC is already updated; it holds in MEM because cycle_1 and cycle_2 are both low.
- HALTED:
  - Terminal state: active = 0; all strobes and requests are 0.
  - Left only via reset.
- active = 1 in every state except HALTED.
- Strobe timing:
  - Exactly one of cycle_1/cycle_2/cycle_3 is high in each non-HALTED cycle.
  - cycle_2 is high for exactly 1 cycle per instruction.
- Minimum latency, no stalls: ALU/branch instruction = 2 cycles; load/store = 3 cycles.
- retired_count wraps from 32'hFFFFFFFF to 0 silently.
- Reset asserted in any state, including mid-stall, aborts the transfer immediately. Requests drop asynchronously.

Optional Feature:
- Macro: CPU_CYCLE_CONTROLLER_WAIT_TIMEOUT_EN.
- When defined:
  - An 8-bit-or-wider wait counter counts consecutive cycles with waitrequest = 1 in FETCH or MEM.
  - It clears on any cycle with waitrequest = 0 and on every state change.
  - When the counter reaches MAX_WAIT, the next state is HALTED and bus_error is set to 1 (sticky until reset).
  - The request drops on entry to HALTED.
- When undefined: no counter; stalls may last indefinitely and bus_error is constant 0.

Test Plan:
- Reset released, pc_address = 32'hBFC00000, waitrequest = 0, non-memory instruction:
  - Required: cycle_1, cycle_2, cycle_1, cycle_2 alternate on consecutive cycles.
  - Required: retired_count = 2 after 4 cycles.
- Load with waitrequest high for 3 cycles in MEM:
  - Required: cycle_3 held for 4 cycles; load_data_en pulses once, in the 4th cycle.
  - Required: mem_read = 1 throughout; cycle_2 seen exactly once.
- Store with waitrequest = 0: sequence FETCH→EXEC→MEM→FETCH; mem_write = 1 only in MEM; mem_addr_sel = 1 there.
- Jump to 0, so pc_address = 0 at the next FETCH:
  - Required: mem_read never asserts; active falls the following cycle and stays 0 for 100 cycles.
- Reset asserted mid-FETCH stall: mem_read drops without waiting for a clock edge; after release, FETCH restarts with retired_count = 0.
- With the macro defined, MAX_WAIT = 4, waitrequest stuck high in FETCH:
  - Required: bus_error = 1 and active = 0 after 4 stall cycles.
  - Required: without the macro, the same stimulus stalls with bus_error = 0 for 1000 cycles.
